mod_up_down_counter: RTL and testbench
======================================

MOD_UP_DOWN_COUNTER -- requirements
Module: mod_up_down_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, count register width in bits (2..32).
REQ-002 SHALL provide parameter MODULUS, default 256, count range 0..MODULUS-1; legal range 2..2^WIDTH.
REQ-003 SHALL provide port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL provide port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port en  input  1  count enable; step taken only when high.
REQ-006 SHALL provide port sel  input  1  direction select (0: down, 1: up).
REQ-007 SHALL provide port load  input  1  synchronous parallel load strobe.
REQ-008 SHALL provide port load_val  input  WIDTH  value captured on load.
REQ-009 SHALL provide port out  output  WIDTH  registered count value.
REQ-010 SHALL provide port tc  output  1  combinational terminal count: high when en=1 and (sel=1 and out=MODULUS-1, or sel=0 and out=0).
REQ-011 SHALL provide port ovf  output  1  registered one-cycle pulse on an up step taken at MODULUS-1.
REQ-012 SHALL provide port unf  output  1  registered one-cycle pulse on a down step taken at 0.

Function
REQ-013 SHALL use clock-edge priority reset > load > en; with none active, out holds and ovf/unf are 0.
REQ-014 SHALL, on load=1, set out to load_val next cycle, or to MODULUS-1 if load_val >= MODULUS; ovf/unf SHALL be 0 that cycle regardless of en.
REQ-015 SHALL, on en=1 and load=0, set out to out+1 (sel=1) or out-1 (sel=0) with one-cycle latency, when not at the bound in the stepping direction.
REQ-016 SHALL, at the bound with en=1 and load=0, follow the REQ-025/REQ-026 boundary behaviour and pulse ovf (up) or unf (down) on the same edge.
REQ-017 SHALL compute all arithmetic modulo MODULUS, never modulo 2^WIDTH, including when MODULUS is not a power of two.
REQ-018 SHALL keep ovf and unf mutually exclusive and each high for exactly one cycle per qualifying step.
REQ-019 SHALL honour a sel change on any cycle; the new direction applies to that edge's step.
REQ-020 SHALL keep out within 0..MODULUS-1 at all times after reset.

Reset
REQ-021 SHALL, while reset=1, force out=0, ovf=0 and unf=0 immediately, independent of clk.
REQ-022 SHALL make tc reflect out=0 during reset (tc=1 if en=1 and sel=0).
REQ-023 SHALL resume counting on the first rising clk edge after reset deasserts; reset mid-count discards the step in progress.
REQ-024 SHALL not rely on initial blocks for state initialisation.

Configuration
REQ-025 SHALL, without macro MOD_UP_DOWN_COUNTER_SAT_EN defined, wrap: up at MODULUS-1 gives 0, down at 0 gives MODULUS-1.
REQ-026 SHALL, with MOD_UP_DOWN_COUNTER_SAT_EN defined, saturate: out holds at MODULUS-1 (up) or 0 (down), while ovf/unf still pulse for each blocked step.

Verification
REQ-027 SHALL cover: WIDTH=4, MODULUS=10, reset then en=1, sel=1 for 12 clocks -> out 1..9,0,1,2; ovf high only on the 9->0 edge; tc high while out=9.
REQ-028 SHALL cover: MODULUS=10, out=0, en=1, sel=0 for 3 clocks -> out 9,8,7 and unf pulse on first edge (wrap build); out 0,0,0 and unf pulse on every edge (SAT build).
REQ-029 SHALL cover: load=1, en=1, load_val=13 with MODULUS=10 -> out=9 next cycle, ovf=unf=0; load_val=4 -> out=4.
REQ-030 SHALL cover: counting up at out=6, assert reset between clock edges -> out=0 without a clock edge; after release, en=1, sel=1 -> out=1 on the first edge.
REQ-031 SHALL cover: WIDTH=8, MODULUS=256, en toggled 1,0,1 with sel=1 from out=255 -> out 0,0,1; ovf pulse only on the first edge.

Source files
------------

// File: rtl/mod_up_down_counter.sv
// Modulo-MODULUS up/down counter with parallel load, terminal count and ovf/unf pulses.
// Define MOD_UP_DOWN_COUNTER_SAT_EN to saturate at the bounds instead of wrapping.
module mod_up_down_counter #(
    parameter int unsigned      WIDTH   = 8,
    parameter longint unsigned  MODULUS = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sel,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2^WIDTH is representable in the load clamp compare.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    logic [WIDTH-1:0] r_out;
    logic             r_ovf;
    logic             r_unf;

    logic [WIDTH-1:0] w_out_next;
    logic             w_ovf_next;
    logic             w_unf_next;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_load_over;

    assign w_at_max    = (r_out == MAX_VAL);
    assign w_at_zero   = (r_out == '0);
    assign w_load_over = ({1'b0, load_val} >= MOD_EXT);

    always_comb begin
        w_out_next = r_out;
        w_ovf_next = 1'b0;
        w_unf_next = 1'b0;
        if (load) begin
            w_out_next = w_load_over ? MAX_VAL : load_val;
        end else if (en) begin
            if (sel) begin
                if (w_at_max) begin
                    w_ovf_next = 1'b1;
`ifdef MOD_UP_DOWN_COUNTER_SAT_EN
                    w_out_next = MAX_VAL;
`else
                    w_out_next = '0;
`endif
                end else begin
                    w_out_next = r_out + 1'b1;
                end
            end else begin
                if (w_at_zero) begin
                    w_unf_next = 1'b1;
`ifdef MOD_UP_DOWN_COUNTER_SAT_EN
                    w_out_next = '0;
`else
                    w_out_next = MAX_VAL;
`endif
                end else begin
                    w_out_next = r_out - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_out <= w_out_next;
            r_ovf <= w_ovf_next;
            r_unf <= w_unf_next;
        end
    end

    assign out = r_out;
    assign ovf = r_ovf;
    assign unf = r_unf;
    assign tc  = en & (sel ? w_at_max : w_at_zero);

endmodule

// File: tb/tb_mod_up_down_counter.sv
// Scoreboard bench: two counter instances (WIDTH=4/MODULUS=10 and WIDTH=8/MODULUS=256)
// share stimulus; an arithmetic model feeds queues that separate monitors drain.
module tb_mod_up_down_counter;

    typedef struct {
        int out;
        bit ovf;
        bit unf;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, sel, load;
    logic [7:0] lv;

    logic [3:0] out0;
    logic       tc0, ovf0, unf0;
    logic [7:0] out1;
    logic       tc1, ovf1, unf1;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   mods[2]  = '{10, 256};
    int   cnt[2];
    exp_t q0[$];
    exp_t q1[$];
    bit   tq0[$];
    bit   tq1[$];

    always #5 clk = ~clk;

    mod_up_down_counter #(.WIDTH(4), .MODULUS(10)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .sel(sel), .load(load),
        .load_val(lv[3:0]), .out(out0), .tc(tc0), .ovf(ovf0), .unf(unf0)
    );

    mod_up_down_counter #(.WIDTH(8), .MODULUS(256)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .sel(sel), .load(load),
        .load_val(lv), .out(out1), .tc(tc1), .ovf(ovf1), .unf(unf1)
    );

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endfunction

    // Reference: plain modular arithmetic on an integer count.
    task automatic model_step(input int k, input bit e, input bit s, input bit ld,
                              input int v, output exp_t x, output bit t);
        int m;
        int c;
        int val;
        m   = mods[k];
        c   = cnt[k];
        val = (k == 0) ? (v % 16) : v;
        t   = e && (s ? (c == m - 1) : (c == 0));
        x.ovf = 0;
        x.unf = 0;
        if (ld) begin
            c = (val >= m) ? m - 1 : val;
        end else if (e) begin
            if (s) begin
                if (c + 1 == m) x.ovf = 1;
`ifdef MOD_UP_DOWN_COUNTER_SAT_EN
                c = x.ovf ? c : c + 1;
`else
                c = (c + 1) % m;
`endif
            end else begin
                if (c == 0) x.unf = 1;
`ifdef MOD_UP_DOWN_COUNTER_SAT_EN
                c = x.unf ? c : c - 1;
`else
                c = (c + m - 1) % m;
`endif
            end
        end
        cnt[k] = c;
        x.out  = c;
    endtask

    // Drive one clock cycle of stimulus; called at posedge+2.
    task automatic cycle(input bit e, input bit s, input bit ld, input int v);
        exp_t x;
        bit   t;
        en   = e;
        sel  = s;
        load = ld;
        lv   = 8'(v);
        model_step(0, e, s, ld, v, x, t);
        q0.push_back(x);
        tq0.push_back(t);
        model_step(1, e, s, ld, v, x, t);
        q1.push_back(x);
        tq1.push_back(t);
        $display("cycle en=%0b sel=%0b load=%0b lv=%0d -> exp0=%0d exp1=%0d",
                 e, s, ld, v, cnt[0], cnt[1]);
        @(posedge clk);
        #2;
    endtask

    // Registered outputs: checked 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (q0.size() > 0) begin
            exp_t x;
            x = q0.pop_front();
            check("out0", int'(out0), x.out);
            check("ovf0", int'(ovf0), int'(x.ovf));
            check("unf0", int'(unf0), int'(x.unf));
        end
        if (q1.size() > 0) begin
            exp_t x;
            x = q1.pop_front();
            check("out1", int'(out1), x.out);
            check("ovf1", int'(ovf1), int'(x.ovf));
            check("unf1", int'(unf1), int'(x.unf));
        end
    end

    // Combinational tc: checked mid-cycle once inputs have settled.
    always begin
        @(negedge clk);
        if (tq0.size() > 0) check("tc0", int'(tc0), int'(tq0.pop_front()));
        if (tq1.size() > 0) check("tc1", int'(tc1), int'(tq1.pop_front()));
    end

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        sel   = 1'b0;
        load  = 1'b0;
        lv    = 8'd0;
        cnt[0] = 0;
        cnt[1] = 0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_out0", int'(out0), 0);
        check("rst_out1", int'(out1), 0);
        check("rst_ovf_unf", int'({ovf0, unf0, ovf1, unf1}), 0);
        check("rst_tc0", int'(tc0), 1);
        check("rst_tc1", int'(tc1), 1);
        reset = 1'b0;

        // Count up 12 clocks: 1..9,0,1,2 on the mod-10 instance.
        for (int i = 0; i < 12; i++) cycle(1, 1, 0, 0);
        // Down 3 clocks from 0.
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        // Load clamp and plain load, with en held high.
        cycle(1, 1, 1, 13);
        cycle(1, 0, 1, 4);
        cycle(0, 0, 1, 200);
        // From 255 on the mod-256 instance: en 1,0,1 with sel=1.
        cycle(0, 1, 1, 255);
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);

        // Asynchronous reset between edges while counting up.
        cycle(1, 1, 1, 6);
        cycle(1, 1, 0, 0);
        en  = 1'b1;
        sel = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        check("async_out0", int'(out0), 0);
        check("async_out1", int'(out1), 0);
        check("async_flags", int'({ovf0, unf0, ovf1, unf1}), 0);
        @(posedge clk);
        #2;
        reset  = 1'b0;
        cnt[0] = 0;
        cnt[1] = 0;
        cycle(1, 1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0), int'($urandom_range(0, 255)));
        end
        en   = 1'b0;
        load = 1'b0;
        @(posedge clk);
        #3;
        check("queue_drain", q0.size() + q1.size() + tq0.size() + tq1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
